maj_vector_sequencer: RTL and testbench



---
 rtl/maj_vector_sequencer.sv | 171 +++++++++++++++++
 tb/tb_maj_vector_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/maj_vector_sequencer.sv
// Majority-gate sweep sequencer: drives all 3-bit vectors, waits a settle
// time, checks NUM_DUT majority outputs against a golden model.
module maj_vector_sequencer #(
  parameter int HOLD_CYCLES = 7,
  parameter int NUM_DUT     = 3,
  parameter int ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_DUT-1:0] w,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2:0]         first_err_vec,
  output logic [NUM_DUT-1:0] first_err_dut
);

  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int PW = $clog2(NUM_DUT + 1);
  localparam int SW = ERR_W + PW + 1;
  localparam logic [CW-1:0]    HOLD    = CW'(HOLD_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [2:0]         idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [2:0]         fev_q, fev_d;
  logic [NUM_DUT-1:0] fed_q, fed_d;

  logic               golden;
  logic [NUM_DUT-1:0] mism;
  logic [PW-1:0]      pc;
  logic [SW-1:0]      sum;

  // Golden majority of the driven vector, per-DUT mismatch and its popcount
  always_comb begin
    golden = (vec_q[2] & vec_q[1]) |
             (vec_q[2] & vec_q[0]) |
             (vec_q[1] & vec_q[0]);
    mism = w ^ {NUM_DUT{golden}};
    pc = '0;
    for (int i = 0; i < NUM_DUT; i++) begin
      pc = pc + PW'(mism[i]);
    end
    sum = SW'(err_q) + SW'(pc);
  end

  // Next-state and result update for the sweep FSM
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fed_d   = fed_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          err_d   = '0;
          fev_d   = '0;
          fed_d   = '0;
          flag_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      APPLY: begin
        vec_d   = idx_q;
        cnt_d   = HOLD;
        state_d = (HOLD_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (sum > SW'(ERR_MAX)) begin
          err_d = ERR_MAX;
        end else begin
          err_d = sum[ERR_W-1:0];
        end
        if ((|mism) && !flag_q) begin
          fev_d  = vec_q;
          fed_d  = mism;
          flag_d = 1'b1;
        end
        if (idx_q == 3'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = APPLY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= '0;
      fed_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fed_q   <= fed_d;
    end
  end

  assign a             = vec_q[2];
  assign b             = vec_q[1];
  assign c             = vec_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = fev_q;
  assign first_err_dut = fed_q;

endmodule

// File: tb/tb_maj_vector_sequencer.sv
// Directed bench for maj_vector_sequencer: full sweeps with modelled DUT
// outputs, saturation, ignored start, async reset and zero settle time.
module tb_maj_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [3];
  logic [2:0] w_v [3];
  logic       a_v [3];
  logic       b_v [3];
  logic       c_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic       pass_v [3];
  logic [2:0] fev_v [3];
  logic [2:0] fed_v [3];
  logic [2:0] abc_v [3];
  logic [7:0] err_v [3];
  logic [7:0] err0, err2;
  logic [2:0] err1;
  int         mode_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maj_vector_sequencer #(.HOLD_CYCLES(2), .NUM_DUT(3), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .w(w_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err0), .first_err_vec(fev_v[0]),
    .first_err_dut(fed_v[0]));

  maj_vector_sequencer #(.HOLD_CYCLES(2), .NUM_DUT(3), .ERR_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .w(w_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err1), .first_err_vec(fev_v[1]),
    .first_err_dut(fed_v[1]));

  maj_vector_sequencer #(.HOLD_CYCLES(0), .NUM_DUT(3), .ERR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .w(w_v[2]),
    .a(a_v[2]), .b(b_v[2]), .c(c_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err2), .first_err_vec(fev_v[2]),
    .first_err_dut(fed_v[2]));

  assign err_v[0] = err0;
  assign err_v[1] = {5'd0, err1};
  assign err_v[2] = err2;

  // mode 0 correct, 1 DUT1 stuck 0, 2 all stuck 1, 3 all inverted
  function automatic logic [2:0] wmodel(input int m, input logic [2:0] v);
    logic g;
    g = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       wmodel = {g, 1'b0, g};
      2:       wmodel = 3'b111;
      3:       wmodel = {3{~g}};
      default: wmodel = {3{g}};
    endcase
  endfunction

  always_comb begin
    for (int u = 0; u < 3; u++) begin
      abc_v[u] = {a_v[u], b_v[u], c_v[u]};
      w_v[u]   = wmodel(mode_v[u], abc_v[u]);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pulse start on instance u, count busy cycles, verify vector stepping.
  // poke >= 0 re-pulses start at that busy cycle.
  task automatic sweep(input int u, input int h, input int poke,
                       output int cyc, output int bad);
    @(negedge clk);
    start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    cyc = 0;
    bad = 0;
    if (done_v[u] !== 1'b0) bad++;
    while (busy_v[u] === 1'b1 && cyc < 500) begin
      if (cyc > 0 && abc_v[u] != 3'((cyc - 1) / (h + 2))) bad++;
      cyc++;
      start_v[u] = (cyc == poke);
      @(negedge clk);
    end
    start_v[u] = 1'b0;
  endtask

  task automatic check_result(input string tag, input int u, input int err,
                              input int fev, input int fed, input int ps);
    check({tag, "_done"}, done_v[u], 1);
    check({tag, "_busy"}, busy_v[u], 0);
    check({tag, "_abc"}, abc_v[u], 7);
    check({tag, "_err"}, err_v[u], err);
    check({tag, "_fev"}, fev_v[u], fev);
    check({tag, "_fed"}, fed_v[u], fed);
    check({tag, "_pass"}, pass_v[u], ps);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    err;
    int    fev;
    int    fed;
    int    ps;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int cyc, bad, n;

    tbl[0] = '{"good", 0, 0, 0, 0, 1};
    tbl[1] = '{"w1lo", 1, 4, 3, 2, 0};
    tbl[2] = '{"allhi", 2, 12, 0, 7, 0};
    tbl[3] = '{"inv", 3, 24, 0, 7, 0};
    tbl[4] = '{"again", 0, 0, 0, 0, 1};

    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0;
      mode_v[u]  = 0;
    end
    mode_v[1] = 3;

    #12;
    check("rst_abc", abc_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_pass", pass_v[0], 0);
    check("rst_err", err_v[0], 0);
    check("rst_fev", fev_v[0], 0);
    check("rst_fed", fed_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      mode_v[0] = tbl[i].mode;
      sweep(0, 2, -1, cyc, bad);
      check({tbl[i].name, "_cycles"}, cyc, 32);
      check({tbl[i].name, "_steps"}, bad, 0);
      check_result(tbl[i].name, 0, tbl[i].err, tbl[i].fev,
                   tbl[i].fed, tbl[i].ps);
    end

    sweep(1, 2, -1, cyc, bad);
    check("sat_cycles", cyc, 32);
    check_result("sat", 1, 7, 0, 7, 0);

    sweep(2, 0, -1, cyc, bad);
    check("h0_cycles", cyc, 16);
    check("h0_steps", bad, 0);
    check_result("h0", 2, 0, 0, 0, 1);

    mode_v[0] = 1;
    sweep(0, 2, 9, cyc, bad);
    check("ign_cycles", cyc, 32);
    check("ign_steps", bad, 0);
    check_result("ign", 0, 4, 3, 2, 0);

    mode_v[0] = 2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (abc_v[0] != 3'd5 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("rst_reach101", abc_v[0], 5);
    check("rst_pre_err", (err_v[0] != 0) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_abc", abc_v[0], 0);
    check("arst_busy", busy_v[0], 0);
    check("arst_done", done_v[0], 0);
    check("arst_err", err_v[0], 0);
    check("arst_fev", fev_v[0], 0);
    check("arst_fed", fed_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy_v[0], 0);
    mode_v[0] = 0;
    sweep(0, 2, -1, cyc, bad);
    check("post_cycles", cyc, 32);
    check("post_steps", bad, 0);
    check_result("post", 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
